// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DataMemory port arbiter.
// Imported by the top module and by the round-robin picker.
package mem_arb_pkg;

  localparam int NPORTS         = 2;
  localparam int MEM_ARB_ADDR_W = 10;
  localparam int MEM_ARB_DATA_W = 32;
  localparam int TMO_W          = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } arb_op_t;

  function automatic logic [NPORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker: grants the sole requester, or on a tie the port
// that did not own the memory last. Purely combinational.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last_owner,
  output logic [NPORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single DataMemory port between instruction-fetch refill (port 0)
// and the data cache controller (port 1), one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = MEM_ARB_ADDR_W,
  parameter int DATA_W  = MEM_ARB_DATA_W,
  parameter int TMO_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Last ACCESS cycle index: abort fires on the TMO_CYC-th cycle without ready.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  arb_state_t        state;
  arb_op_t           op;
  logic              owner;
  logic              last_owner;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [NPORTS-1:0] req_any;
  logic [NPORTS-1:0] pick_gnt;
  logic              sel_port;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_any = req_rd | req_wr;

  mem_arb_rr_pick u_pick (
    .req        (req_any),
    .last_owner (last_owner),
    .grant      (pick_gnt)
  );

  // Write wins when a port raises both read and write (write-through ordering).
  always_comb begin
    sel_port  = pick_gnt[1];
    sel_wr    = 1'b0;
    sel_addr  = req_addr0;
    sel_wdata = req_wdata0;
    if (sel_port) begin
      sel_wr    = req_wr[1];
      sel_addr  = req_addr1;
      sel_wdata = req_wdata1;
    end else begin
      sel_wr    = req_wr[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARB_IDLE;
      op           <= OP_RD;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      tmo_cnt      <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      rdata        <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        ARB_IDLE: begin
          if (|pick_gnt) begin
            gnt          <= pick_gnt;
            owner        <= sel_port;
            op           <= sel_wr ? OP_WR : OP_RD;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            mem_write_en <= sel_wr;
            mem_read_en  <= ~sel_wr;
            tmo_cnt      <= '0;
            state        <= ARB_ACCESS;
          end
        end

        ARB_ACCESS: begin
          if (mem_ready) begin
            if (op == OP_RD) rdata <= mem_rdata;
            done         <= port_onehot(owner);
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            last_owner   <= owner;
            state        <= ARB_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Aborted owner still counts as served so the other port is not starved.
            err          <= port_onehot(owner);
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            last_owner   <= owner;
            state        <= ARB_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ARB_RELEASE: begin
          gnt   <= '0;
          state <= ARB_IDLE;
        end

        default: begin
          gnt          <= '0;
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          state        <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
